// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ADD/SUB/AND/ORR alu between two valid/ready requesters.
// Latency: 2 cycles from accept to response valid; one operation in flight; responses hold until accepted.
// Optional feature macro: ALU_ARB_TIMEOUT_EN (drops an unaccepted response after TIMEOUT_CYCLES RESP cycles).

module alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  ctrl_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        c;
    logic        v;

    always_comb begin
        // SUB is A + ~B + 1, so C is "no borrow"
        b_eff    = ctrl_i[0] ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, ctrl_i[0]};
        result_o = sum[31:0];
        c        = 1'b0;
        v        = 1'b0;
        case (ctrl_i)
            2'b00, 2'b01: begin
                result_o = sum[31:0];
                c        = sum[32];
                v        = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
            end
            2'b10:   result_o = a_i & b_i;
            default: result_o = a_i | b_i;
        endcase
        flags_o = {result_o[31], (result_o == 32'd0), c, v};
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy,
    output logic             err_timeout
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             owner_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic             grant_vld;
    logic             grant_idx;
    logic             accept;
    logic             rsp_accept;
    logic             timeout_drop;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .ctrl_i   (op_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // On a tie the requester that did not win last time gets the grant
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        case (req_valid)
            2'b01: begin grant_vld = 1'b1; grant_idx = 1'b0;          end
            2'b10: begin grant_vld = 1'b1; grant_idx = 1'b1;          end
            2'b11: begin grant_vld = 1'b1; grant_idx = ~last_grant_q; end
            default: ;
        endcase
    end

    assign accept     = (state_q == IDLE) && grant_vld;
    assign rsp_accept = (state_q == RESP) && rsp_ready[owner_q];

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_accept || timeout_drop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (accept)            req_ready[grant_idx] = 1'b1;
        if (state_q == RESP)   rsp_valid[owner_q]   = 1'b1;
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 2'b00;
            result_q     <= '0;
            flags_q      <= 4'b0000;
        end else begin
            if (accept) begin
                owner_q      <= grant_idx;
                last_grant_q <= grant_idx;
                a_q          <= grant_idx ? req_a1  : req_a0;
                b_q          <= grant_idx ? req_b1  : req_b0;
                op_q         <= grant_idx ? req_op1 : req_op0;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
            end
        end
    end

    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

`ifdef ALU_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       err_q;

    // Acceptance on the limit cycle wins over the drop
    assign timeout_drop = (state_q == RESP) && !rsp_accept && (tmo_cnt_q == TMO_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            if (state_q != RESP)  tmo_cnt_q <= 8'd0;
            else if (!rsp_accept) tmo_cnt_q <= tmo_cnt_q + 8'd1;
            if (timeout_drop)     err_q     <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_tmo;
    assign unused_tmo   = ^TMO_LIMIT;
    assign timeout_drop = 1'b0;
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single transactions plus arbitration/backpressure/reset sequences.
module tb_alu_arbiter;
    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_op0, req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // advance one edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (r == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
        else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic do_txn(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] res, input logic [3:0] flg);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        set_req(r, a, b, op);
        req_valid = oh; rsp_ready = 2'b11;
        #1;
        chk("txn_req_ready", 32'(req_ready), 32'(oh));
        tick();
        req_valid = 2'b00;
        #1;
        chk("txn_exec_busy", 32'(busy), 32'd1);
        tick();
        chk("txn_rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("txn_result", rsp_result, res);
        chk("txn_flags", 32'(rsp_flags), 32'(flg));
        tick();
        chk("txn_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("txn_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 32'd5,         32'd5,         2'b01, 32'h0000_0000, 4'b0110};
        vecs[1] = '{0, 32'h7FFF_FFFF, 32'd1,         2'b00, 32'h8000_0000, 4'b1001};
        vecs[2] = '{1, 32'h0000_00F0, 32'h0000_000F, 2'b11, 32'h0000_00FF, 4'b0000};
        vecs[3] = '{1, 32'hFFFF_0000, 32'h0000_FFFF, 2'b10, 32'h0000_0000, 4'b0100};
        vecs[4] = '{0, 32'hFFFF_FFFF, 32'd1,         2'b00, 32'h0000_0000, 4'b0110};
        vecs[5] = '{1, 32'd0,         32'd1,         2'b01, 32'hFFFF_FFFF, 4'b1000};
        vecs[6] = '{0, 32'h8000_0000, 32'd1,         2'b01, 32'h7FFF_FFFF, 4'b0011};
        vecs[7] = '{1, 32'd3,         32'd4,         2'b00, 32'h0000_0007, 4'b0000};

        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = 2'b00; req_op1 = 2'b00;
        do_reset();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_flags", 32'(rsp_flags), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg);

        // reset while in EXEC: the aborted operation must never respond
        set_req(0, 32'd10, 32'd20, 2'b00);
        req_valid = 2'b01; rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", rsp_result, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // both requesting continuously right after reset: grants 0,1,0
        set_req(0, 32'h7FFF_FFFF, 32'd1, 2'b00);
        set_req(1, 32'h0000_00F0, 32'h0000_000F, 2'b11);
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        chk("rr_grant0", 32'(req_ready), 32'b01);
        tick();
        chk("rr_exec_ready", 32'(req_ready), 32'b00);
        tick();
        chk("rr_rsp0_valid", 32'(rsp_valid), 32'b01);
        chk("rr_rsp0_result", rsp_result, 32'h8000_0000);
        chk("rr_rsp0_flags", 32'(rsp_flags), 32'b1001);
        chk("rr_resp_ready", 32'(req_ready), 32'b00);
        tick();
        chk("rr_grant1", 32'(req_ready), 32'b10);
        tick(); tick();
        chk("rr_rsp1_valid", 32'(rsp_valid), 32'b10);
        chk("rr_rsp1_result", rsp_result, 32'h0000_00FF);
        chk("rr_rsp1_flags", 32'(rsp_flags), 32'b0000);
        tick();
        chk("rr_grant0_again", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        tick();
        chk("rr_dropped_valid_idle", 32'(busy), 32'd0);

        // response backpressure on requester 1 while requester 0 waits
        set_req(1, 32'hFFFF_0000, 32'h0000_FFFF, 2'b10);
        set_req(0, 32'd5, 32'd5, 2'b01);
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b01;
        #1;
        chk("bp_exec_ready", 32'(req_ready), 32'b00);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'b10);
            chk("bp_result", rsp_result, 32'd0);
            chk("bp_flags", 32'(rsp_flags), 32'b0100);
            chk("bp_req_ready", 32'(req_ready), 32'b00);
        end
        rsp_ready = 2'b10;
        tick();
        chk("bp_idle_grant0", 32'(req_ready), 32'b01);
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        tick();
        chk("bp_r0_result", rsp_result, 32'd0);
        chk("bp_r0_flags", 32'(rsp_flags), 32'b0110);
        chk("bp_r0_valid", 32'(rsp_valid), 32'b01);
        tick();

        // owner is 0, only requester 1 accepts: response must stay pending
        set_req(0, 32'd9, 32'd3, 2'b01);
        req_valid = 2'b01; rsp_ready = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("wrong_owner_pending", 32'(rsp_valid), 32'b01);
            tick();
        end
        chk("wrong_owner_result", rsp_result, 32'd6);
        rsp_ready = 2'b01;
        tick();
        chk("wrong_owner_released", 32'(rsp_valid), 32'b00);

        // response never accepted
        set_req(1, 32'd1, 32'd2, 2'b00);
        req_valid = 2'b10; rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        tick();
`ifdef ALU_ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            chk("tmo_pending", 32'(rsp_valid), 32'b10);
            tick();
        end
        chk("tmo_dropped", 32'(rsp_valid), 32'b00);
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_err_set", 32'(err_timeout), 32'd1);
        do_txn(0, 32'd7, 32'd2, 2'b01, 32'd5, 4'b0010);
        chk("tmo_err_sticky", 32'(err_timeout), 32'd1);
`else
        for (int k = 0; k < 20; k++) tick();
        chk("notmo_pending", 32'(rsp_valid), 32'b10);
        chk("notmo_err", 32'(err_timeout), 32'd0);
        rsp_ready = 2'b10;
        tick();
        chk("notmo_released", 32'(rsp_valid), 32'b00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
